immgen_stage: RTL and testbench
===============================

// Module: immgen_stage
// PURPOSE
//  Registered immediate-generation stage for the decode pipeline: decodes the sign-extended immediate
//  for every RV32I/RV64I base format, classifies the format, and flags illegal opcodes. Sits between
//  fetch and register-read with valid/ready handshakes on both sides and a 2-entry skid buffer so
//  out_ready_i never drives in_ready_o combinationally. Keeps a saturating illegal-opcode counter.
// PARAMETERS
//  XLEN   32  immediate width; legal values 32 or 64, any other value is an elaboration error
//  TAG_W  32  width of the sideband tag (PC) that travels alongside the instruction
//  CNT_W  8   width of the saturating illegal-opcode counter
// PORTS
//  clk_i        in   1      clock; everything is on the rising edge
//  rst_ni       in   1      synchronous active-low reset
//  flush_i      in   1      drop all buffered entries; higher priority than in/out handshakes
//  in_valid_i   in   1      instruction valid
//  in_ready_o   out  1      stage can accept an instruction
//  instr_i      in   32     instruction word
//  tag_i        in   TAG_W  sideband tag, passed through unchanged
//  out_valid_o  out  1      decoded result valid
//  out_ready_i  in   1      consumer accepts the result
//  imm_o        out  XLEN   sign-extended immediate
//  fmt_o        out  3      imm_fmt_e: NONE,I,S,B,U,J
//  illegal_o    out  1      opcode not among the base opcodes listed below
//  tag_o        out  TAG_W  tag of the presented result
//  illegal_cnt_o out CNT_W  saturating count of illegal instructions accepted at the output
// BEHAVIOUR
//  Reset (rst_ni=0 at an edge): both entries invalid; out_valid_o=0, in_ready_o=1, imm_o=0, fmt_o=NONE,
//   illegal_o=0, tag_o=0, illegal_cnt_o=0. Reset mid-transfer drops all data; nothing is replayed.
//  Decode (combinational on instr_i, registered at accept):
//   I: OP-IMM 0010011, LOAD 0000011, JALR 1100111 -> {sext instr[31:20]}
//   S: STORE 0100011 -> {sext instr[31:25],instr[11:7]}
//   B: BRANCH 1100011 -> {sext instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
//   U: LUI 0110111, AUIPC 0010111 -> {sext instr[31:12],12'b0}; for XLEN=64 bits 63:32 copy bit 31
//   J: JAL 1101111 -> {sext instr[31],instr[19:12],instr[20],instr[30:21],1'b0}
//   NONE, legal: OP 0110011, SYSTEM 1110011, MISC-MEM 0001111 -> imm=0, illegal=0
//   any other opcode (incl. 0x00000000) -> imm=0, fmt=NONE, illegal=1; never X
//   XLEN=64 adds OP-IMM-32 0011011 (I) and OP-32 0111011 (NONE); with XLEN=32 both are illegal
//  Handshake: transfer when valid&ready at a clock edge; latency 1 cycle in->out at empty stage.
//   2-entry FIFO (main+skid); in_ready_o = registered "fewer than 2 entries held", i.e. it falls
//   the cycle after the second entry is captured. Same-cycle accept+drain on full stage impossible
//   (in_ready_o=0); on 1 entry, simultaneous accept+drain keeps 1 entry with the new data.
//   out_valid_o stays high and imm_o/fmt_o/illegal_o/tag_o stay stable until out_ready_i.
//   Strict in-order delivery; no entry is dropped or duplicated.
//  Flush: at the edge, both entries invalidated, input that cycle ignored; counter untouched.
//  Counter: +1 on each output transfer with illegal_o=1; holds at 2^CNT_W-1; cleared only by reset.
// STRUCTURE
//  Package riscv_imm_pkg: imm_fmt_e enum (3b), opcode localparams (OPC_OP_IMM, OPC_LOAD, ...),
//   XLEN-generic sign-extend function.
//  Sub-module imm_decode (combinational: instr -> imm, fmt, illegal; parameter XLEN); immgen_stage
//   owns the 2-entry buffer, handshake logic and counter.
// TESTING
//  addi x1,x0,-1 0xFFF00093 -> 1 cycle later imm_o=0xFFFFFFFF, fmt=I, illegal=0
//  sw x1,-4(x2) 0xFE112E23 -> 0xFFFFFFFC fmt=S; beq x0,x0,-4 0xFE000EE3 -> 0xFFFFFFFC fmt=B
//  lui x5,0x12345 0x123452B7 -> 0x12345000 fmt=U; XLEN=64 lui 0x800000B7 -> 0xFFFFFFFF80000000
//  out_ready_i=0 for 4 cycles with 3 instrs offered -> 2 accepted, in_ready_o=0, then drained in order
//  0x00000000 accepted 300 times with CNT_W=8 -> illegal_o=1, imm_o=0, illegal_cnt_o saturates at 255
//  flush_i or rst_ni=0 with 2 entries held -> next cycle out_valid_o=0, in_ready_o=1, no stale output

Source files
------------

// File: rtl/riscv_imm_pkg.sv
// Shared definitions for the immediate-generation stage.
//   imm_fmt_e  : immediate format classification (3 bits)
//   OPC_*      : RV32I/RV64I base opcodes (instr[6:0])
//   sext32_to_64 : widens a 32-bit immediate to 64 bits by replicating bit 31
package riscv_imm_pkg;

  typedef enum logic [2:0] {
    ImmNone = 3'd0,
    ImmI    = 3'd1,
    ImmS    = 3'd2,
    ImmB    = 3'd3,
    ImmU    = 3'd4,
    ImmJ    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  function automatic logic [63:0] sext32_to_64(input logic [31:0] val);
    return {{32{val[31]}}, val};
  endfunction

endpackage

// File: rtl/immgen_stage_if.sv
// Handshake bundle of the immediate-generation stage.
//   in_valid/in_ready/instr/tag             : fetch side (instruction in)
//   out_valid/out_ready/imm/fmt/illegal/out_tag : register-read side (decoded result out)
// Modports: slave = the stage itself, master = the environment around it.
interface immgen_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) ();
  import riscv_imm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  imm_fmt_e         fmt;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, instr, tag, out_ready,
    output in_ready, out_valid, imm, fmt, illegal, out_tag
  );

  modport master (
    output in_valid, instr, tag, out_ready,
    input  in_ready, out_valid, imm, fmt, illegal, out_tag
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder.
//   instr_i   : instruction word
//   imm_o     : sign-extended immediate (0 for formats without one and for illegal opcodes)
//   fmt_o     : immediate format
//   illegal_o : opcode is not a base opcode for this XLEN
module imm_decode
  import riscv_imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  logic [6:0]  w_opcode;
  logic [31:0] w_imm32;

  assign w_opcode = instr_i[6:0];

  always_comb begin
    fmt_o     = ImmNone;
    illegal_o = 1'b0;
    case (w_opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt_o = ImmI;
      OPC_STORE:                      fmt_o = ImmS;
      OPC_BRANCH:                     fmt_o = ImmB;
      OPC_LUI, OPC_AUIPC:             fmt_o = ImmU;
      OPC_JAL:                        fmt_o = ImmJ;
      OPC_OP, OPC_SYSTEM, OPC_MISC_MEM: fmt_o = ImmNone;
      OPC_OP_IMM_32: begin
        if (XLEN == 64) fmt_o = ImmI;
        else            illegal_o = 1'b1;
      end
      OPC_OP_32: begin
        if (XLEN != 64) illegal_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

  // Every format fits in 32 bits; wider XLEN only replicates bit 31.
  always_comb begin
    w_imm32 = '0;
    case (fmt_o)
      ImmI: w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      ImmS: w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      ImmB: w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                       instr_i[11:8], 1'b0};
      ImmU: w_imm32 = {instr_i[31:12], 12'b0};
      ImmJ: w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                       instr_i[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  if (XLEN == 64) begin : g_rv64
    assign imm_o = sext32_to_64(w_imm32);
  end else begin : g_rv32
    assign imm_o = w_imm32;
  end

endmodule

// File: rtl/immgen_stage.sv
// Registered immediate-generation stage with a 2-entry (main + skid) buffer.
//   clk_i         : clock, rising edge
//   rst_ni        : synchronous active-low reset
//   flush_i       : drop all held entries, ignore input this cycle
//   bus_io        : immgen_stage_if.slave (instruction in, decoded result out)
//   illegal_cnt_o : saturating count of illegal results delivered at the output
module immgen_stage
  import riscv_imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  immgen_stage_if.slave    bus_io,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("immgen_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] w_dec_imm;
  imm_fmt_e        w_dec_fmt;
  logic            w_dec_ill;

  imm_decode #(
    .XLEN (XLEN)
  ) u_imm_decode (
    .instr_i   (bus_io.instr),
    .imm_o     (w_dec_imm),
    .fmt_o     (w_dec_fmt),
    .illegal_o (w_dec_ill)
  );

  // main is the head (presented at the output), skid holds the younger entry.
  entry_t           r_main, r_skid, w_main_d, w_skid_d, w_new;
  logic             r_main_vld, r_skid_vld, w_main_vld_d, w_skid_vld_d;
  logic             r_in_ready, w_in_ready_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             w_push, w_pop;

  assign w_new = '{imm: w_dec_imm, fmt: w_dec_fmt, illegal: w_dec_ill, tag: bus_io.tag};

  assign w_push = bus_io.in_valid & r_in_ready & ~flush_i;
  assign w_pop  = bus_io.out_ready & r_main_vld & ~flush_i;

  always_comb begin
    w_main_vld_d = r_main_vld;
    w_skid_vld_d = r_skid_vld;
    w_main_d     = r_main;
    w_skid_d     = r_skid;
    if (flush_i) begin
      w_main_vld_d = 1'b0;
      w_skid_vld_d = 1'b0;
    end else begin
      if (w_pop) begin
        w_main_vld_d = r_skid_vld;
        w_main_d     = r_skid;
        w_skid_vld_d = 1'b0;
      end
      // Push can only happen with a free slot, so one of the two is open here.
      if (w_push) begin
        if (!w_main_vld_d) begin
          w_main_vld_d = 1'b1;
          w_main_d     = w_new;
        end else begin
          w_skid_vld_d = 1'b1;
          w_skid_d     = w_new;
        end
      end
    end
    // Registered so out_ready never reaches in_ready combinationally.
    w_in_ready_d = ~(w_main_vld_d & w_skid_vld_d);
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_pop && r_main.illegal && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
      r_cnt      <= '0;
    end else begin
      r_main_vld <= w_main_vld_d;
      r_skid_vld <= w_skid_vld_d;
      r_in_ready <= w_in_ready_d;
      r_main     <= w_main_d;
      r_skid     <= w_skid_d;
      r_cnt      <= w_cnt_d;
    end
  end

  // Payload is masked when empty so nothing stale is visible after drain or flush.
  assign bus_io.in_ready  = r_in_ready;
  assign bus_io.out_valid = r_main_vld;
  assign bus_io.imm       = r_main_vld ? r_main.imm : '0;
  assign bus_io.fmt       = r_main_vld ? r_main.fmt : ImmNone;
  assign bus_io.illegal   = r_main_vld & r_main.illegal;
  assign bus_io.out_tag   = r_main_vld ? r_main.tag : '0;
  assign illegal_cnt_o    = r_cnt;

endmodule

// File: tb/tb_immgen_stage.sv
// Self-checking bench: an XLEN=32 and an XLEN=64 stage driven by identical stimulus and
// compared against a queue-based reference model with arithmetic immediate decoding.
module tb_immgen_stage;

  logic        clk;
  logic        rst_n;
  logic        d_flush;
  logic        d_valid;
  logic [31:0] d_instr;
  logic [31:0] d_tag;
  logic        d_ready;
  logic [7:0]  cnt32, cnt64;

  immgen_stage_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  immgen_stage_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  assign bus32.in_valid  = d_valid;
  assign bus32.instr     = d_instr;
  assign bus32.tag       = d_tag;
  assign bus32.out_ready = d_ready;
  assign bus64.in_valid  = d_valid;
  assign bus64.instr     = d_instr;
  assign bus64.tag       = d_tag;
  assign bus64.out_ready = d_ready;

  immgen_stage #(.XLEN(32), .TAG_W(32), .CNT_W(8)) u_dut32 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (d_flush),
    .bus_io        (bus32.slave),
    .illegal_cnt_o (cnt32)
  );

  immgen_stage #(.XLEN(64), .TAG_W(32), .CNT_W(8)) u_dut64 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (d_flush),
    .bus_io        (bus64.slave),
    .illegal_cnt_o (cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm32;
    logic [63:0] imm64;
    int          fmt32;
    int          fmt64;
    bit          ill32;
    bit          ill64;
    logic [31:0] tag;
  } exp_t;

  exp_t q[$];
  int   m_cnt32, m_cnt64;
  int   n_checks, n_pass;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Immediate value from the field layout, sign applied by subtracting the field range.
  function automatic void ref_decode(input logic [31:0] ins, input bit rv64,
                                     output longint imm, output int fmt, output bit ill);
    longint v;
    imm = 0;
    fmt = 0;
    ill = 1'b0;
    v   = 0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin
        fmt = 1;
        v = longint'(ins[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      7'h23: begin
        fmt = 2;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      7'h63: begin
        fmt = 3;
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 +
            longint'(ins[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      7'h37, 7'h17: begin
        fmt = 4;
        v = longint'(ins[31:12]) * 4096;
        if (v >= 64'd2147483648) v = v - 64'd4294967296;
      end
      7'h6F: begin
        fmt = 5;
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
            longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v = v - 2097152;
      end
      7'h33, 7'h73, 7'h0F: fmt = 0;
      7'h1B: begin
        if (rv64) begin
          fmt = 1;
          v = longint'(ins[31:20]);
          if (v >= 2048) v = v - 4096;
        end else begin
          ill = 1'b1;
        end
      end
      7'h3B: if (!rv64) ill = 1'b1;
      default: ill = 1'b1;
    endcase
    imm = v;
  endfunction

  function automatic exp_t make_exp(input logic [31:0] ins, input logic [31:0] tg);
    exp_t   e;
    longint imm;
    int     fmt;
    bit     ill;
    ref_decode(ins, 1'b0, imm, fmt, ill);
    e.imm32 = {32'h0, imm[31:0]};
    e.fmt32 = fmt;
    e.ill32 = ill;
    ref_decode(ins, 1'b1, imm, fmt, ill);
    e.imm64 = imm;
    e.fmt64 = fmt;
    e.ill64 = ill;
    e.tag   = tg;
    return e;
  endfunction

  task automatic check_outputs();
    bit ev;
    ev = (q.size() > 0);
    check("in_ready32", 64'(bus32.in_ready), 64'(q.size() < 2));
    check("in_ready64", 64'(bus64.in_ready), 64'(q.size() < 2));
    check("out_valid32", 64'(bus32.out_valid), 64'(ev));
    check("out_valid64", 64'(bus64.out_valid), 64'(ev));
    if (ev) begin
      check("imm32", 64'(bus32.imm), q[0].imm32);
      check("fmt32", 64'(bus32.fmt), 64'(q[0].fmt32));
      check("ill32", 64'(bus32.illegal), 64'(q[0].ill32));
      check("tag32", 64'(bus32.out_tag), 64'(q[0].tag));
      check("imm64", bus64.imm, q[0].imm64);
      check("fmt64", 64'(bus64.fmt), 64'(q[0].fmt64));
      check("ill64", 64'(bus64.illegal), 64'(q[0].ill64));
      check("tag64", 64'(bus64.out_tag), 64'(q[0].tag));
    end
    check("cnt32", 64'(cnt32), 64'(m_cnt32));
    check("cnt64", 64'(cnt64), 64'(m_cnt64));
  endtask

  task automatic model_update();
    bit can_push, do_pop;
    if (!rst_n) begin
      q.delete();
      m_cnt32 = 0;
      m_cnt64 = 0;
    end else if (d_flush) begin
      q.delete();
    end else begin
      can_push = d_valid && (q.size() < 2);
      do_pop   = d_ready && (q.size() > 0);
      if (do_pop) begin
        if (q[0].ill32 && m_cnt32 < 255) m_cnt32++;
        if (q[0].ill64 && m_cnt64 < 255) m_cnt64++;
        void'(q.pop_front());
      end
      if (can_push) q.push_back(make_exp(d_instr, d_tag));
    end
  endtask

  // Check current outputs, clock once, advance the model; returns at the falling edge.
  task automatic step();
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drain();
    d_valid = 1'b0;
    d_ready = 1'b1;
    d_flush = 1'b0;
    repeat (3) step();
  endtask

  task automatic expect_one(input string name, input logic [31:0] ins, input logic [63:0] e32,
                            input logic [63:0] e64, input int fmt);
    d_valid = 1'b1;
    d_instr = ins;
    d_tag   = $urandom;
    d_ready = 1'b0;
    step();
    d_valid = 1'b0;
    check({name, "_valid"}, 64'(bus32.out_valid), 64'(1));
    check({name, "_imm32"}, 64'(bus32.imm), e32);
    check({name, "_imm64"}, bus64.imm, e64);
    check({name, "_fmt"}, 64'(bus32.fmt), 64'(fmt));
    check({name, "_ill"}, 64'(bus32.illegal), 64'(0));
    d_ready = 1'b1;
    step();
    d_ready = 1'b0;
  endtask

  task automatic check_empty(input string name, input bit with_cnt);
    check({name, "_out_valid"}, 64'(bus32.out_valid), 64'(0));
    check({name, "_in_ready"}, 64'(bus32.in_ready), 64'(1));
    check({name, "_imm"}, 64'(bus32.imm), 64'(0));
    check({name, "_fmt"}, 64'(bus32.fmt), 64'(0));
    check({name, "_ill"}, 64'(bus32.illegal), 64'(0));
    check({name, "_tag"}, 64'(bus32.out_tag), 64'(0));
    check({name, "_imm64"}, bus64.imm, 64'(0));
    if (with_cnt) check({name, "_cnt"}, 64'(cnt32), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  opc_tab [0:13];
    logic [31:0] bp_instr [0:2];
    logic [31:0] ins;
    int          acc, guard, r;
    bit          will;

    opc_tab  = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                 7'h6F, 7'h33, 7'h73, 7'h0F, 7'h1B, 7'h3B, 7'h00};
    bp_instr = '{32'hFFF00093, 32'hFE112E23, 32'h123452B7};
    n_checks = 0;
    n_pass   = 0;
    m_cnt32  = 0;
    m_cnt64  = 0;
    rst_n    = 1'b0;
    d_flush  = 1'b0;
    d_valid  = 1'b0;
    d_instr  = '0;
    d_tag    = '0;
    d_ready  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    model_update();
    @(negedge clk);
    check_empty("reset", 1'b1);
    check("reset_cnt64", 64'(cnt64), 64'(0));
    rst_n = 1'b1;

    // Directed vectors, one instruction into an empty stage each
    expect_one("addi", 32'hFFF00093, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    expect_one("sw",   32'hFE112E23, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 2);
    expect_one("beq",  32'hFE000EE3, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3);
    expect_one("lui",  32'h123452B7, 64'h1234_5000, 64'h0000_0000_1234_5000, 4);
    expect_one("luin", 32'h800000B7, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 4);
    expect_one("jal",  32'hFF9FF06F, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 5);
    drain();

    // Backpressure: 3 offered over 4 stalled cycles, only 2 fit
    d_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      d_valid = (acc < 3);
      d_instr = bp_instr[acc % 3];
      d_tag   = 32'h100 + 32'(acc);
      will    = d_valid && (q.size() < 2);
      step();
      if (will) acc++;
    end
    d_valid = 1'b0;
    check("bp_in_ready", 64'(bus32.in_ready), 64'(0));
    check("bp_out_valid", 64'(bus32.out_valid), 64'(1));
    d_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("bp_order_tag", 64'(bus32.out_tag), 64'(32'h100 + 32'(i)));
      step();
    end
    check("bp_drained", 64'(bus32.out_valid), 64'(0));

    // Flush with both entries held (illegal ones, so a leaked transfer would count)
    d_ready = 1'b0;
    d_valid = 1'b1;
    d_instr = 32'h0;
    step();
    step();
    check("fl_full", 64'(bus32.in_ready), 64'(0));
    d_flush = 1'b1;
    d_instr = 32'hFFF00093;
    d_ready = 1'b1;
    step();
    d_flush = 1'b0;
    d_valid = 1'b0;
    check_empty("flush", 1'b1);
    step();

    // Saturation: 300 all-zero instructions
    d_instr = 32'h0;
    d_valid = 1'b1;
    d_ready = 1'b1;
    acc = 0;
    guard = 0;
    while (acc < 300 && guard < 1000) begin
      will = d_valid && (q.size() < 2);
      step();
      if (will) acc++;
      guard++;
    end
    check("sat_accepts", 64'(acc), 64'(300));
    d_valid = 1'b0;
    repeat (3) step();
    check("sat_cnt32", 64'(cnt32), 64'(255));
    check("sat_cnt64", 64'(cnt64), 64'(255));

    // Reset with both entries held
    d_ready = 1'b0;
    d_valid = 1'b1;
    d_instr = 32'h123452B7;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    d_valid = 1'b0;
    check_empty("rst2", 1'b1);
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r   = $urandom_range(0, 15);
      ins = $urandom;
      if (r < 14) ins[6:0] = opc_tab[r];
      d_instr = ins;
      d_tag   = $urandom;
      d_valid = ($urandom_range(0, 3) != 0);
      d_ready = ($urandom_range(0, 2) != 0);
      d_flush = ($urandom_range(0, 40) == 0);
      rst_n   = ($urandom_range(0, 500) != 0);
      step();
    end
    rst_n   = 1'b1;
    d_flush = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
